instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction-memory and fetch stage directly upstream of the 8-bit single-cycle core. It drives the core's `instr` from its `pc` and holds the core in reset while a program loads. A program is streamed in byte-by-byte over a valid/ready handshake, run under FSM control, and stopped on a halt instruction. Everything runs on the core's 1 Hz `clk_1s` domain.

Parameters:
- ADDR_W, 8, width of pc and memory address.
- DEPTH, 256, instruction memory words; must be ≤ 2^ADDR_W.
- HALT_INSTR, 8'hFF, halt opcode; encodes a taken branch with imm -1, i.e. branch-to-self.

Ports:
- clk_1s  in  1  system clock, shared with the core.
- reset  in  1  asynchronous, active-high.
- load_start  in  1  pulse; begin program load.
- load_valid  in  1  load_data is valid.
- load_data  in  8  instruction byte.
- load_last  in  1  qualifies the final byte of the load.
- load_ready  out  1  unit accepts a byte this cycle.
- load_done  out  1  one-cycle pulse when the load completes.
- run_start  in  1  pulse; begin execution.
- pc  in  ADDR_W  core program counter.
- instr  out  8  instruction presented to the core.
- cpu_hold  out  1  registered; integrator ORs this into the core reset.
- prog_len  out  ADDR_W+1  number of valid loaded words.
- state  out  2  FSM state.
- halted  out  1  high in HALT.
- cycle_count  out  16  executed cycles in RUN, saturating.

Behaviour:
- Reset is async, active-high; clock is clk_1s. Reset values:
  - state = IDLE, prog_len = 0, wr_ptr = 0.
  - cycle_count = 0, load_ready = 0, load_done = 0, halted = 0, cpu_hold = 1.
  - Memory contents are not cleared.
- State encoding: IDLE = 0, LOAD = 1, RUN = 2, HALT = 3.
- IDLE:
  - load_start → LOAD, with wr_ptr = 0 and prog_len = 0.
  - Otherwise, run_start with prog_len > 0 → RUN.
  - run_start with prog_len = 0 is ignored.
  - If load_start and run_start are asserted together, load wins.
- LOAD:
  - load_ready = 1 (combinational on state).
  - On load_valid & load_ready: mem[wr_ptr] ← load_data, then wr_ptr++.
  - If load_last is set on that beat: prog_len ← wr_ptr + 1, load_done pulses the next cycle, state → IDLE.
  - If the beat writes address DEPTH-1 without load_last: prog_len ← DEPTH, load_done pulses, → IDLE. Any further bytes are not accepted.
  - load_start and run_start are ignored in LOAD.
- RUN:
  - instr is a combinational read: mem[pc] if pc < prog_len, else HALT_INSTR.
  - cycle_count increments once per clock in RUN and saturates at 16'hFFFF.
  - If instr == HALT_INSTR this cycle → HALT next edge. The core's branch-to-self keeps pc stable.
  - load_start in RUN → LOAD (abort). run_start in RUN is ignored.
- HALT:
  - instr = HALT_INSTR and halted = 1.
  - run_start → RUN with cycle_count cleared. cpu_hold pulses 1 for one cycle so the core pc restarts at 0.
  - load_start → LOAD.
- Outside RUN, instr = HALT_INSTR.
- cpu_hold:
  - Registered; = 1 in IDLE and LOAD, and for the first cycle after entering RUN from HALT.
  - = 0 otherwise.
  - The core is therefore released from pc = 0 on the cycle RUN is entered from IDLE.
- Memory: synchronous write, asynchronous read; pc bits above log2(DEPTH) are compared against prog_len, not truncated.
- Reset mid-load or mid-run returns to IDLE. Partially loaded words remain, but prog_len = 0 makes them unreachable.

Optional Feature:
IFU_BREAKPOINT_EN:
- When defined, adds ports bp_en (in, 1), bp_addr (in, ADDR_W) and bp_hit (out, 1, reset 0).
- In RUN, bp_en & pc == bp_addr → HALT next edge, with bp_hit = 1 until the next run_start or load_start.
- When undefined, there are no such ports and HALT is reached only on HALT_INSTR.

Decomposition:
- Shared package ifu_pkg holds:
  - state encodings: S_IDLE, S_LOAD, S_RUN, S_HALT;
  - HALT_INSTR default;
  - core opcode constants.
- One sub-module, imem_ram: DEPTH × 8, synchronous write port, async read port.

Test Plan:
1. Reset, load bytes 8'h41, 8'h82, 8'hFF (last on 3rd) → prog_len = 3, load_done one pulse, state = IDLE, cpu_hold = 1.
2. run_start; core/bench pc 0,1,2 → instr 8'h41, 8'h82, 8'hFF. HALT one edge after pc = 2, halted = 1, cycle_count = 3.
3. load_valid held with load_ready gaps: deassert load_valid for 2 cycles mid-stream → no write, wr_ptr unchanged, and the final contents match the sent bytes.
4. Load 256 bytes without load_last → prog_len = 256, auto return to IDLE, 257th byte not accepted (load_ready = 0).
5. run_start with prog_len = 0 stays in IDLE. pc = 5 with prog_len = 3 → instr = 8'hFF → HALT.
6. Assert reset mid-LOAD after 2 bytes → state = IDLE, prog_len = 0, cpu_hold = 1, load_ready = 0 immediately (async).

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, core opcodes, halt word.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } ifu_state_e;

    // Core instruction layout: opcode in [7:6], operand/immediate in [5:0].
    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_ALU = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_BR  = 2'b11;

    // Taken branch with imm = -1: the core spins on itself.
    localparam logic [7:0] HALT_INSTR_DEF = {OP_BR, 6'h3F};

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } load_beat_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Load handshake and fetch bus between the loader/core side (master) and the fetch unit (slave).
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              load_start;
    logic              load_valid;
    logic [7:0]        load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic              run_start;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        instr;

    modport master (
        output load_start, load_valid, load_data, load_last, run_start, pc,
        input  load_ready, load_done, instr
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, run_start, pc,
        output load_ready, load_done, instr
    );
endinterface

// File: rtl/imem_ram.sv
// Instruction memory: DEPTH x 8, synchronous write, asynchronous read, contents survive reset.
module imem_ram
    import ifu_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_1s,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk_1s) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Program loader + fetch stage for the 8-bit core. Optional breakpoint compare under
// IFU_BREAKPOINT_EN (adds bp_en, bp_addr, bp_hit).
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int         ADDR_W     = 8,
    parameter int         DEPTH      = 256,
    parameter logic [7:0] HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic              clk_1s,
    input  logic              reset,
    instr_fetch_unit_if.slave bus,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   prog_len,
    output logic [1:0]        state,
    output logic              halted,
    output logic [15:0]       cycle_count
`ifdef IFU_BREAKPOINT_EN
    ,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              bp_hit
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ifu_state_e        st, st_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic              load_done_q;
    logic              beat, beat_end, enter_load, enter_run;
    logic              in_range, bp_match;
    logic [7:0]        ram_rdata, instr_w;
    load_beat_t        beat_in;

    assign beat_in = '{data: bus.load_data, last: bus.load_last};

    imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_imem (
        .clk_1s (clk_1s),
        .we     (beat),
        .waddr  (wr_ptr[AW-1:0]),
        .wdata  (beat_in.data),
        .raddr  (bus.pc[AW-1:0]),
        .rdata  (ram_rdata)
    );

    // Full-width compare so out-of-range pc never aliases onto low memory.
    assign in_range = ({1'b0, bus.pc} < prog_len);
    assign instr_w  = (st == S_RUN && in_range) ? ram_rdata : HALT_INSTR;

`ifdef IFU_BREAKPOINT_EN
    assign bp_match = bp_en && (bus.pc == bp_addr);
`else
    assign bp_match = 1'b0;
`endif

    assign beat     = bus.load_valid && (st == S_LOAD);
    assign beat_end = beat && (beat_in.last || wr_ptr == LAST_ADDR);

    always_comb begin
        st_nxt     = st;
        enter_load = 1'b0;
        enter_run  = 1'b0;
        unique case (st)
            S_IDLE: begin
                if (bus.load_start) begin
                    st_nxt     = S_LOAD;
                    enter_load = 1'b1;
                end else if (bus.run_start && prog_len != '0) begin
                    st_nxt    = S_RUN;
                    enter_run = 1'b1;
                end
            end
            S_LOAD: begin
                if (beat_end) st_nxt = S_IDLE;
            end
            S_RUN: begin
                if (bus.load_start) begin
                    st_nxt     = S_LOAD;
                    enter_load = 1'b1;
                end else if (instr_w == HALT_INSTR || bp_match) begin
                    st_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (bus.load_start) begin
                    st_nxt     = S_LOAD;
                    enter_load = 1'b1;
                end else if (bus.run_start) begin
                    st_nxt    = S_RUN;
                    enter_run = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) st <= S_IDLE;
        else       st <= st_nxt;
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            prog_len    <= '0;
            cycle_count <= '0;
            load_done_q <= 1'b0;
            cpu_hold    <= 1'b1;
        end else begin
            load_done_q <= beat_end;
            // Hold one extra cycle on HALT->RUN so the core restarts from pc 0.
            cpu_hold    <= (st_nxt == S_IDLE) || (st_nxt == S_LOAD) ||
                           (st == S_HALT && enter_run);
            if (enter_load) begin
                wr_ptr   <= '0;
                prog_len <= '0;
            end else if (beat) begin
                if (beat_in.last)            prog_len <= {1'b0, wr_ptr} + (ADDR_W+1)'(1);
                else if (wr_ptr == LAST_ADDR) prog_len <= (ADDR_W+1)'(DEPTH);
                if (!beat_end)               wr_ptr   <= wr_ptr + ADDR_W'(1);
            end
            if (enter_run)
                cycle_count <= '0;
            else if (st == S_RUN && cycle_count != 16'hFFFF)
                cycle_count <= cycle_count + 16'd1;
        end
    end

`ifdef IFU_BREAKPOINT_EN
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset)                                            bp_hit <= 1'b0;
        else if (enter_load || enter_run)                     bp_hit <= 1'b0;
        else if (st == S_RUN && !bus.load_start && bp_match)  bp_hit <= 1'b1;
    end
`endif

    assign bus.load_ready = (st == S_LOAD);
    assign bus.load_done  = load_done_q;
    assign bus.instr      = instr_w;
    assign state          = st;
    assign halted         = (st == S_HALT);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed table, hand sequences, and random traffic vs a reference model.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    logic        clk_1s = 1'b0;
    logic        reset  = 1'b0;
    logic        cpu_hold, halted;
    logic [8:0]  prog_len;
    logic [1:0]  state;
    logic [15:0] cycle_count;

    instr_fetch_unit_if #(.ADDR_W(8)) bus ();

`ifdef IFU_BREAKPOINT_EN
    logic       bp_en   = 1'b0;
    logic [7:0] bp_addr = 8'h00;
    logic       bp_hit;
`endif

    instr_fetch_unit #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk_1s      (clk_1s),
        .reset       (reset),
        .bus         (bus),
        .cpu_hold    (cpu_hold),
        .prog_len    (prog_len),
        .state       (state),
        .halted      (halted),
        .cycle_count (cycle_count)
`ifdef IFU_BREAKPOINT_EN
        ,
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .bp_hit      (bp_hit)
`endif
    );

    always #5 clk_1s = ~clk_1s;

    typedef struct {
        logic [1:0]  st;
        logic [8:0]  plen;
        logic [7:0]  instr;
        logic        rdy, done, hold, hlt;
        logic [15:0] cc;
    } obs_t;

    typedef struct {
        logic       ls, lv;
        logic [7:0] ld;
        logic       ll, rs;
        logic [7:0] pc;
        obs_t       exp;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: states 0 idle, 1 load, 2 run, 3 halt.
    int         m_st, m_plen, m_wp, m_cc;
    bit         m_hold, m_done;
    logic [7:0] m_mem [256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] m_instr(input logic [7:0] p);
        return (m_st == 2 && int'(p) < m_plen) ? m_mem[p] : 8'hFF;
    endfunction

    function automatic obs_t model_obs(input logic [7:0] p);
        obs_t e;
        e.st = 2'(m_st); e.plen = 9'(m_plen); e.instr = m_instr(p);
        e.rdy = (m_st == 1); e.done = m_done; e.hold = m_hold; e.hlt = (m_st == 3);
        e.cc = 16'(m_cc);
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.plen = prog_len; o.instr = bus.instr; o.rdy = bus.load_ready;
        o.done = bus.load_done; o.hold = cpu_hold; o.hlt = halted; o.cc = cycle_count;
        return o;
    endfunction

    task automatic cmp_obs(input string tag, input obs_t o, input obs_t e);
        chk({tag, ".state"}, 32'(o.st), 32'(e.st));
        chk({tag, ".prog_len"}, 32'(o.plen), 32'(e.plen));
        chk({tag, ".instr"}, 32'(o.instr), 32'(e.instr));
        chk({tag, ".load_ready"}, 32'(o.rdy), 32'(e.rdy));
        chk({tag, ".load_done"}, 32'(o.done), 32'(e.done));
        chk({tag, ".cpu_hold"}, 32'(o.hold), 32'(e.hold));
        chk({tag, ".halted"}, 32'(o.hlt), 32'(e.hlt));
        chk({tag, ".cycle_count"}, 32'(o.cc), 32'(e.cc));
    endtask

    task automatic model_reset();
        m_st = 0; m_plen = 0; m_wp = 0; m_cc = 0; m_hold = 1; m_done = 0;
    endtask

    task automatic model_update(input logic ls, lv, input logic [7:0] ld,
                                input logic ll, rs, input logic [7:0] p);
        int nst = m_st;
        logic [7:0] cur = m_instr(p);
        m_done = 0;
        if (m_st == 0) begin
            if (ls) begin nst = 1; m_wp = 0; m_plen = 0; end
            else if (rs && m_plen > 0) begin nst = 2; m_cc = 0; end
        end else if (m_st == 1) begin
            if (lv) begin
                m_mem[m_wp] = ld;
                if (ll)              begin m_plen = m_wp + 1; nst = 0; m_done = 1; end
                else if (m_wp == 255) begin m_plen = 256;      nst = 0; m_done = 1; end
                else m_wp++;
            end
        end else if (m_st == 2) begin
            if (m_cc < 65535) m_cc++;
            if (ls) begin nst = 1; m_wp = 0; m_plen = 0; end
            else if (cur == 8'hFF) nst = 3;
        end else begin
            if (ls) begin nst = 1; m_wp = 0; m_plen = 0; end
            else if (rs) begin nst = 2; m_cc = 0; end
        end
        m_hold = (nst == 0 || nst == 1 || (m_st == 3 && nst == 2));
        m_st = nst;
    endtask

    task automatic step(input logic ls, lv, input logic [7:0] ld, input logic ll, rs,
                        input logic [7:0] pcv, input bit mchk, output obs_t o);
        bus.load_start = ls; bus.load_valid = lv; bus.load_data = ld;
        bus.load_last = ll; bus.run_start = rs; bus.pc = pcv;
        @(negedge clk_1s);
        o = sample();
        if (mchk) cmp_obs("model", o, model_obs(pcv));
        @(posedge clk_1s);
        model_update(ls, lv, ld, ll, rs, pcv);
        #1;
    endtask

    // Async reset: outputs must settle before any clock edge.
    task automatic do_reset(input string tag);
        bus.load_start = 0; bus.load_valid = 0; bus.load_data = 0;
        bus.load_last = 0; bus.run_start = 0; bus.pc = 0;
        reset = 1'b1;
        #1;
        chk({tag, ".state"}, 32'(state), 32'd0);
        chk({tag, ".prog_len"}, 32'(prog_len), 32'd0);
        chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, ".load_ready"}, 32'(bus.load_ready), 32'd0);
        #2 reset = 1'b0;
        model_reset();
        @(posedge clk_1s); #1;
    endtask

    function automatic vec_t mk(input logic ls, lv, input logic [7:0] ld, input logic ll, rs,
                                input logic [7:0] pc, input logic [1:0] st, input logic [8:0] plen,
                                input logic [7:0] ins, input logic rdy, done, hold, hlt,
                                input logic [15:0] cc);
        vec_t v;
        v.ls = ls; v.lv = lv; v.ld = ld; v.ll = ll; v.rs = rs; v.pc = pc;
        v.exp.st = st; v.exp.plen = plen; v.exp.instr = ins; v.exp.rdy = rdy;
        v.exp.done = done; v.exp.hold = hold; v.exp.hlt = hlt; v.exp.cc = cc;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        obs_t o;
        logic [7:0] sent [4];
        sent[0] = 8'h11; sent[1] = 8'h22; sent[2] = 8'h33; sent[3] = 8'h44;

        //         ls lv ld    ll rs pc    | st plen instr rdy done hold hlt cc
        tbl.push_back(mk(0,0,8'h00,0,0,8'd0, 0,0,8'hFF,0,0,1,0,0));
        tbl.push_back(mk(1,0,8'h00,0,0,8'd0, 0,0,8'hFF,0,0,1,0,0));
        tbl.push_back(mk(0,1,8'h41,0,0,8'd0, 1,0,8'hFF,1,0,1,0,0));
        tbl.push_back(mk(0,1,8'h82,0,0,8'd0, 1,0,8'hFF,1,0,1,0,0));
        tbl.push_back(mk(0,1,8'hFF,1,0,8'd0, 1,0,8'hFF,1,0,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,8'd0, 0,3,8'hFF,0,1,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,8'd0, 0,3,8'hFF,0,0,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,8'd0, 2,3,8'h41,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,8'd1, 2,3,8'h82,0,0,0,0,1));
        tbl.push_back(mk(0,0,8'h00,0,0,8'd2, 2,3,8'hFF,0,0,0,0,2));
        tbl.push_back(mk(0,0,8'h00,0,0,8'd2, 3,3,8'hFF,0,0,0,1,3));
        tbl.push_back(mk(0,0,8'h00,0,1,8'd2, 3,3,8'hFF,0,0,0,1,3));
        tbl.push_back(mk(0,0,8'h00,0,0,8'd0, 2,3,8'h41,0,0,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,8'd5, 2,3,8'hFF,0,0,0,0,1));
        tbl.push_back(mk(0,0,8'h00,0,0,8'd5, 3,3,8'hFF,0,0,0,1,2));
        tbl.push_back(mk(1,0,8'h00,0,0,8'd5, 3,3,8'hFF,0,0,0,1,2));
        tbl.push_back(mk(0,0,8'h00,0,0,8'd0, 1,0,8'hFF,1,0,1,0,2));
        tbl.push_back(mk(0,1,8'h10,1,0,8'd0, 1,0,8'hFF,1,0,1,0,2));
        tbl.push_back(mk(1,0,8'h00,0,1,8'd0, 0,1,8'hFF,0,1,1,0,2));
        tbl.push_back(mk(0,1,8'h20,1,0,8'd0, 1,0,8'hFF,1,0,1,0,2));
        tbl.push_back(mk(0,0,8'h00,0,1,8'd0, 0,1,8'hFF,0,1,1,0,2));
        tbl.push_back(mk(1,0,8'h00,0,0,8'd0, 2,1,8'h20,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,8'd0, 1,0,8'hFF,1,0,1,0,1));
        tbl.push_back(mk(0,1,8'h33,1,0,8'd0, 1,0,8'hFF,1,0,1,0,1));
        tbl.push_back(mk(0,0,8'h00,0,0,8'd0, 0,1,8'hFF,0,1,1,0,1));

        #1 do_reset("reset0");
        foreach (tbl[i]) begin
            step(tbl[i].ls, tbl[i].lv, tbl[i].ld, tbl[i].ll, tbl[i].rs, tbl[i].pc, 1'b0, o);
            cmp_obs($sformatf("vec%0d", i), o, tbl[i].exp);
        end

        // run_start with an empty program is ignored
        do_reset("reset1");
        step(0,0,8'h00,0,1,8'd0,1'b1,o);
        step(0,0,8'h00,0,0,8'd0,1'b1,o);
        chk("empty_run.state", 32'(o.st), 32'd0);

        // load with two idle cycles mid-stream, then read back
        step(1,0,8'h00,0,0,8'd0,1'b1,o);
        step(0,1,sent[0],0,0,8'd0,1'b1,o);
        step(0,1,sent[1],0,0,8'd0,1'b1,o);
        step(0,0,8'hEE,0,0,8'd0,1'b1,o);
        step(0,0,8'hEE,0,0,8'd0,1'b1,o);
        step(0,1,sent[2],0,0,8'd0,1'b1,o);
        step(0,1,sent[3],1,0,8'd0,1'b1,o);
        step(0,0,8'h00,0,1,8'd0,1'b1,o);
        chk("gap.prog_len", 32'(o.plen), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(0,0,8'h00,0,0,8'(i),1'b1,o);
            chk($sformatf("gap.instr%0d", i), 32'(o.instr), 32'(sent[i]));
        end
        step(0,0,8'h00,0,0,8'd4,1'b1,o);
        step(0,0,8'h00,0,0,8'd4,1'b1,o);
        chk("gap.halted", 32'(o.hlt), 32'd1);

        // full memory without load_last: auto-complete, extra byte refused
        step(1,0,8'h00,0,0,8'd0,1'b1,o);
        for (int i = 0; i < 256; i++) step(0,1,8'(i % 255),0,0,8'd0,1'b1,o);
        step(0,1,8'h99,0,0,8'd0,1'b1,o);
        chk("full.state", 32'(o.st), 32'd0);
        chk("full.prog_len", 32'(o.plen), 32'd256);
        chk("full.load_done", 32'(o.done), 32'd1);
        chk("full.load_ready", 32'(o.rdy), 32'd0);
        step(0,1,8'h99,0,0,8'd0,1'b1,o);
        chk("full.done_pulse", 32'(o.done), 32'd0);
        step(0,0,8'h00,0,1,8'd0,1'b1,o);
        for (int i = 0; i < 256; i++) step(0,0,8'h00,0,0,8'(i),1'b1,o);

        // abort into a load, then reset after two bytes
        step(1,0,8'h00,0,0,8'd0,1'b1,o);
        step(0,1,8'hAB,0,0,8'd0,1'b1,o);
        step(0,1,8'hCD,0,0,8'd0,1'b1,o);
        do_reset("midload");
        step(0,0,8'h00,0,1,8'd3,1'b1,o);
        step(0,0,8'h00,0,0,8'd0,1'b1,o);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic ls, lv, ll, rs;
            logic [7:0] ld, p;
            int hi;
            ls = ($urandom_range(0, 99) < 4);
            rs = ($urandom_range(0, 99) < 12);
            lv = ($urandom_range(0, 99) < 60);
            ll = ($urandom_range(0, 99) < 15);
            ld = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            hi = (m_plen + 1 > 255) ? 255 : m_plen + 1;
            p  = 8'($urandom_range(0, hi));
            step(ls, lv, ld, ll, rs, p, 1'b1, o);
            if (c % 1000 == 999) do_reset("rnd_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
